// File: rtl/reg_file_mp_pkg.sv
// reg_file_pkg: shared constants, types and helpers for the multi-port
// register file (reg_file_mp) and its scoreboard.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_addr_t           : register address type for the default configuration
//   popcount             : counts set bits of a busy vector (up to POP_MAX bits)
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Widest busy vector popcount accepts; narrower vectors are zero-extended.
  localparam int POP_MAX   = 256;
  localparam int POP_CNT_W = $clog2(POP_MAX) + 1;

  typedef logic [4:0] reg_addr_t;

  function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      c = c + POP_CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bundles the read ports, writeback, issue and flush signals
// of reg_file_mp.
//   master : decode/writeback side (drives addresses, writeback, issue, flush)
//   slave  : register file side (returns read data, busy flags, iss_ready,
//            busy_cnt)
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) ();

  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                rd_wr_en;
  logic [AW-1:0]       rd_addr;
  logic [XLEN-1:0]     rd_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output rs_addr, rd_wr_en, rd_addr, rd_data, iss_valid, iss_rd, flush,
    input  rs_data, rs_busy, iss_ready, busy_cnt
  );

  modport slave (
    input  rs_addr, rd_wr_en, rd_addr, rd_data, iss_valid, iss_rd, flush,
    output rs_data, rs_busy, iss_ready, busy_cnt
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: one pending-write bit per register (register 0 never
// busy), issue acceptance, flush and registered busy count.
//   clk, rst     : clock, asynchronous active-high reset
//   wr_en_i      : writeback enable          wr_addr_i : writeback register
//   iss_valid_i  : issue request             iss_rd_i  : issue destination
//   flush_i      : clear all marks, block issue this cycle
//   iss_ready_o  : issue accepted (combinational)
//   busy_o       : raw busy bits             busy_cnt_o: count of busy bits
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_rd_i,
  input  logic             flush_i,
  output logic             iss_ready_o,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      busy_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             accept;

  // A writeback landing on the requested register this cycle frees it, so
  // the new producer may claim it on the same edge.
  assign iss_ready_o = ~busy_q[iss_rd_i] | (wr_en_i & (wr_addr_i == iss_rd_i)) |
                       (iss_rd_i == '0);
  assign accept      = iss_valid_i & iss_ready_o & ~flush_i & (iss_rd_i != '0);

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wr_en_i && wr_addr_i != '0) busy_d[wr_addr_i] = 1'b0;
      // Applied after the clear: the newly issued producer owns the register.
      if (accept) busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    cnt_d = (AW+1)'(popcount(POP_MAX'(busy_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with integrated
// write scoreboard. Register 0 is hardwired to zero and never busy.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reg_file_mp_if slave port
//              rs_addr/rs_data/rs_busy : NRD combinational read ports
//              rd_wr_en/rd_addr/rd_data: writeback
//              iss_valid/iss_rd/iss_ready: issue marking
//              flush, busy_cnt
// BYPASS=1 makes a same-cycle writeback visible on reads (write-first).
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input logic            clk,
  input logic            rst,
  reg_file_mp_if.slave   bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy;
  logic             byp_en;
  logic             byp;
  logic [AW-1:0]    ra;

  reg_file_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.rd_wr_en),
    .wr_addr_i  (bus.rd_addr),
    .iss_valid_i(bus.iss_valid),
    .iss_rd_i   (bus.iss_rd),
    .flush_i    (bus.flush),
    .iss_ready_o(bus.iss_ready),
    .busy_o     (busy),
    .busy_cnt_o (bus.busy_cnt)
  );

  // Entry 0 is never written, so it stays at its reset value.
  always_comb begin
    regs_d = regs_q;
    if (bus.rd_wr_en && bus.rd_addr != '0) regs_d[bus.rd_addr] = bus.rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is suppressed while in reset so read data is forced to zero.
  assign byp_en = (BYPASS != 0) & ~rst & bus.rd_wr_en;

  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    ra          = '0;
    byp         = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = bus.rs_addr[i*AW +: AW];
      byp = byp_en & (bus.rd_addr == ra);
      if (ra != '0) begin
        bus.rs_data[i*XLEN +: XLEN] = byp ? bus.rd_data : regs_q[ra];
        bus.rs_busy[i]              = busy[ra] & ~byp;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int ND = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(XL), .NREGS(NR), .NRD(ND)) ifb ();
  reg_file_mp_if #(.XLEN(XL), .NREGS(NR), .NRD(ND)) ifn ();

  reg_file_mp #(.XLEN(XL), .NREGS(NR), .NRD(ND), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));
  reg_file_mp #(.XLEN(XL), .NREGS(NR), .NRD(ND), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .bus(ifn.slave));

  reg_addr_t   ra0, ra1, wa, ird;
  logic        we, iv, fl;
  logic [31:0] wd;

  assign ifb.rs_addr = {ra1, ra0};
  assign ifb.rd_wr_en = we;
  assign ifb.rd_addr = wa;
  assign ifb.rd_data = wd;
  assign ifb.iss_valid = iv;
  assign ifb.iss_rd = ird;
  assign ifb.flush = fl;
  assign ifn.rs_addr = {ra1, ra0};
  assign ifn.rd_wr_en = we;
  assign ifn.rd_addr = wa;
  assign ifn.rd_data = wd;
  assign ifn.iss_valid = iv;
  assign ifn.iss_rd = ird;
  assign ifn.flush = fl;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  // Behavioural model: register contents and pending marks as plain arrays.
  logic [31:0] m_mem [32];
  bit          m_busy[32];

  function automatic bit m_ready();
    return (ird == 0) || !m_busy[ird] || (we && wa == ird);
  endfunction

  function automatic logic [31:0] m_data(input bit byp, input reg_addr_t a);
    if (a == 0) return 32'h0;
    if (byp && !rst && we && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic bit m_bsy(input bit byp, input reg_addr_t a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(byp && we && wa == a);
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  <= '0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      if (fl) begin
        for (int r = 0; r < 32; r++) m_busy[r] <= 1'b0;
      end else begin
        if (we && wa != 0) m_busy[wa] <= 1'b0;
        if (iv && ird != 0 && m_ready()) m_busy[ird] <= 1'b1;
      end
      if (we && wa != 0) m_mem[wa] <= wd;
    end
  end

  // Every-cycle comparison of both configurations against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < ND; i++) begin
        reg_addr_t a;
        a = (i == 0) ? ra0 : ra1;
        chk($sformatf("byp_data%0d", i), 64'(ifb.rs_data[i*XL +: XL]), 64'(m_data(1'b1, a)));
        chk($sformatf("byp_busy%0d", i), 64'(ifb.rs_busy[i]), 64'(m_bsy(1'b1, a)));
        chk($sformatf("nb_data%0d", i), 64'(ifn.rs_data[i*XL +: XL]), 64'(m_data(1'b0, a)));
        chk($sformatf("nb_busy%0d", i), 64'(ifn.rs_busy[i]), 64'(m_bsy(1'b0, a)));
      end
      chk("byp_ready", 64'(ifb.iss_ready), 64'(m_ready()));
      chk("nb_ready", 64'(ifn.iss_ready), 64'(m_ready()));
      chk("byp_cnt", 64'(ifb.busy_cnt), 64'(m_cnt()));
      chk("nb_cnt", 64'(ifn.busy_cnt), 64'(m_cnt()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; iv = 1'b0; fl = 1'b0;
  endtask

  initial begin
    ra0 = 5'd5; ra1 = 5'd5; wa = '0; wd = '0; ird = '0;
    we = 1'b0; iv = 1'b0; fl = 1'b0;

    #3 rst = 1'b1;
    chk_on = 1'b1;
    #1;
    chk("rst_data0", 64'(ifb.rs_data[31:0]), 64'h0);
    chk("rst_data1", 64'(ifn.rs_data[63:32]), 64'h0);
    chk("rst_busy", 64'(ifb.rs_busy), 64'h0);
    chk("rst_cnt", 64'(ifb.busy_cnt), 64'h0);
    chk("rst_ready", 64'(ifb.iss_ready), 64'h1);
    #8 rst = 1'b0;

    // Same-cycle write and read of x3
    step(); we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF; ra0 = 5'd3; ra1 = 5'd3;
    #2;
    chk("wr_byp_p0", 64'(ifb.rs_data[31:0]), 64'hFFFF_FFFF);
    chk("wr_byp_p1", 64'(ifb.rs_data[63:32]), 64'hFFFF_FFFF);
    chk("wr_nb_p0", 64'(ifn.rs_data[31:0]), 64'h0);
    step(); idle();
    #2;
    chk("wr_nb_next", 64'(ifn.rs_data[63:32]), 64'hFFFF_FFFF);

    // Issue x4, re-issue refused, writeback clears
    step(); iv = 1'b1; ird = 5'd4; ra0 = 5'd4; ra1 = 5'd4;
    #2 chk("iss4_ready", 64'(ifb.iss_ready), 64'h1);
    step(); iv = 1'b0;
    #2;
    chk("x4_busy", 64'(ifb.rs_busy[0]), 64'h1);
    chk("x4_cnt", 64'(ifb.busy_cnt), 64'h1);
    step(); iv = 1'b1;
    #2 chk("waw_refused", 64'(ifb.iss_ready), 64'h0);
    step(); iv = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'hAAAA_AAAA;
    #2;
    chk("wb4_byp_busy", 64'(ifb.rs_busy[0]), 64'h0);
    chk("wb4_nb_busy", 64'(ifn.rs_busy[0]), 64'h1);
    step(); idle();
    #2;
    chk("wb4_cnt", 64'(ifn.busy_cnt), 64'h0);
    chk("wb4_data", 64'(ifn.rs_data[31:0]), 64'hAAAA_AAAA);

    // Same-edge writeback and re-issue of x7
    step(); iv = 1'b1; ird = 5'd7; ra0 = 5'd7; ra1 = 5'd7;
    step(); iv = 1'b0;
    step(); we = 1'b1; wa = 5'd7; wd = 32'h0BAD_F00D; iv = 1'b1;
    #2 chk("x7_ready", 64'(ifn.iss_ready), 64'h1);
    step(); idle();
    #2;
    chk("x7_data", 64'(ifn.rs_data[31:0]), 64'h0BAD_F00D);
    chk("x7_busy", 64'(ifb.rs_busy[1]), 64'h1);
    chk("x7_cnt", 64'(ifb.busy_cnt), 64'h1);
    step(); we = 1'b1; wa = 5'd7; wd = 32'h77;
    step(); idle();

    // x0 is hardwired
    step(); we = 1'b1; wa = 5'd0; wd = 32'h1234_5678; iv = 1'b1; ird = 5'd0; ra0 = 5'd0; ra1 = 5'd0;
    #2;
    chk("x0_byp", 64'(ifb.rs_data[31:0]), 64'h0);
    chk("x0_ready", 64'(ifb.iss_ready), 64'h1);
    step(); idle();
    #2;
    chk("x0_data", 64'(ifn.rs_data[63:32]), 64'h0);
    chk("x0_cnt", 64'(ifn.busy_cnt), 64'h0);

    // Fill three marks, then flush with a concurrent writeback and issue
    step(); iv = 1'b1; ird = 5'd1;
    step(); ird = 5'd2;
    step(); ird = 5'd9;
    step(); iv = 1'b0; ra0 = 5'd9; ra1 = 5'd10;
    #2 chk("cnt3", 64'(ifb.busy_cnt), 64'h3);
    step(); fl = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h55; iv = 1'b1; ird = 5'd10;
    step(); idle();
    #2;
    chk("fl_cnt", 64'(ifb.busy_cnt), 64'h0);
    chk("fl_x9", 64'(ifn.rs_data[31:0]), 64'h55);
    chk("fl_x10_busy", 64'(ifb.rs_busy[1]), 64'h0);
    ra0 = 5'd1;
    #1 chk("fl_x1_busy", 64'(ifn.rs_busy[0]), 64'h0);

    // Mid-cycle asynchronous reset
    step(); iv = 1'b1; ird = 5'd5;
    step(); iv = 1'b0; we = 1'b1; wa = 5'd6; wd = 32'h66;
    step(); we = 1'b0; ra0 = 5'd6; ra1 = 5'd5; iv = 1'b1; ird = 5'd5;
    #2;
    chk("pre_rst_data", 64'(ifb.rs_data[31:0]), 64'h66);
    chk("pre_rst_busy", 64'(ifb.rs_busy[1]), 64'h1);
    chk("pre_rst_ready", 64'(ifb.iss_ready), 64'h0);
    #1 rst = 1'b1;
    #1;
    chk("async_data", 64'(ifb.rs_data[31:0]), 64'h0);
    chk("async_busy", 64'(ifn.rs_busy), 64'h0);
    chk("async_cnt", 64'(ifb.busy_cnt), 64'h0);
    chk("async_ready", 64'(ifn.iss_ready), 64'h1);
    iv = 1'b0;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
